// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready flow control and synchronous flush.
// SKID=1 adds a second entry so that in_ready comes straight from a flop.
//
// state | meaning
// EMPTY | no word held, out_valid=0
// ONE   | main entry valid, presented on out_*
// TWO   | main and skid valid, in_ready=0
module pipe_stage_reg #(
   parameter int              DATA_W = 32,
   parameter int              NFIELD = 4,
   parameter int              PC_W   = 32,
   parameter logic [PC_W-1:0] PC_RST = 32'h0000_3008,
   parameter bit              SKID   = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NFIELD*DATA_W-1:0] in_data,
   input  logic [PC_W-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NFIELD*DATA_W-1:0] out_data,
   output logic [PC_W-1:0]          out_pc,
   output logic [1:0]               occupancy
);

   localparam int W = NFIELD * DATA_W;

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   generate
      if (SKID) begin : g_skid
         typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

         state_t          state;
         logic [W-1:0]    skid_data;
         logic [PC_W-1:0] skid_pc;
         logic            in_ready_q;

         assign in_ready = in_ready_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state      <= EMPTY;
               out_valid  <= 1'b0;
               out_data   <= '0;
               out_pc     <= PC_RST;
               skid_data  <= '0;
               skid_pc    <= '0;
               in_ready_q <= 1'b1;
               occupancy  <= 2'd0;
            end else if (flush) begin
               // bubble still carries the current PC for branch/exception bookkeeping
               state      <= EMPTY;
               out_valid  <= 1'b0;
               out_data   <= '0;
               out_pc     <= in_pc;
               skid_data  <= '0;
               skid_pc    <= '0;
               in_ready_q <= 1'b1;
               occupancy  <= 2'd0;
            end else begin
               case (state)
                  EMPTY: begin
                     if (in_fire) begin
                        out_data  <= in_data;
                        out_pc    <= in_pc;
                        out_valid <= 1'b1;
                        occupancy <= 2'd1;
                        state     <= ONE;
                     end
                  end
                  ONE: begin
                     if (in_fire && out_fire) begin
                        out_data <= in_data;
                        out_pc   <= in_pc;
                     end else if (in_fire) begin
                        skid_data  <= in_data;
                        skid_pc    <= in_pc;
                        in_ready_q <= 1'b0;
                        occupancy  <= 2'd2;
                        state      <= TWO;
                     end else if (out_fire) begin
                        out_valid <= 1'b0;
                        occupancy <= 2'd0;
                        state     <= EMPTY;
                     end
                  end
                  TWO: begin
                     if (out_fire) begin
                        out_data   <= skid_data;
                        out_pc     <= skid_pc;
                        in_ready_q <= 1'b1;
                        occupancy  <= 2'd1;
                        state      <= ONE;
                     end
                  end
                  default: begin
                     state      <= EMPTY;
                     out_valid  <= 1'b0;
                     in_ready_q <= 1'b1;
                     occupancy  <= 2'd0;
                  end
               endcase
            end
         end
      end else begin : g_single
         assign in_ready  = out_ready | ~out_valid;
         assign occupancy = {1'b0, out_valid};

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               out_valid <= 1'b0;
               out_data  <= '0;
               out_pc    <= PC_RST;
            end else if (flush) begin
               out_valid <= 1'b0;
               out_data  <= '0;
               out_pc    <= in_pc;
            end else if (in_fire) begin
               out_valid <= 1'b1;
               out_data  <= in_data;
               out_pc    <= in_pc;
            end else if (out_fire) begin
               out_valid <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a SKID=1 default instance and a SKID=0 narrow instance.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic         a_flush = 0, a_in_valid = 0, a_out_ready = 0;
   logic         a_in_ready, a_out_valid;
   logic [127:0] a_in_data = '0, a_out_data;
   logic [31:0]  a_in_pc = '0, a_out_pc;
   logic [1:0]   a_occ;

   logic         b_flush = 0, b_in_valid = 0, b_out_ready = 0;
   logic         b_in_ready, b_out_valid;
   logic [31:0]  b_in_data = '0, b_out_data;
   logic [31:0]  b_in_pc = '0, b_out_pc;
   logic [1:0]   b_occ;

   logic [127:0] a_dq[$];
   logic [31:0]  a_pq[$];
   logic [31:0]  b_dq[$];
   logic [31:0]  b_pq[$];

   pipe_stage_reg u_a (
      .clk(clk), .rst(rst), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_pc(a_in_pc),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_pc(a_out_pc), .occupancy(a_occ)
   );

   pipe_stage_reg #(.DATA_W(16), .NFIELD(2), .SKID(1'b0)) u_b (
      .clk(clk), .rst(rst), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_pc(b_in_pc),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_pc(b_out_pc), .occupancy(b_occ)
   );

   function automatic logic [127:0] wa(int v);
      return {32'(v + 3), 32'(v + 2), 32'(v + 1), 32'(v)};
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(int v, logic [31:0] pc);
      a_in_valid = 1'b1;
      a_in_data  = wa(v);
      a_in_pc    = pc;
   endtask

   // monitors: pop and compare whenever the DUT completes an output transfer
   always @(negedge clk) begin
      if (rst === 1'b1 && a_out_valid && a_out_ready) begin
         if (a_dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected actual=%0h required=none", a_out_data);
         end else begin
            chk("a_data", a_out_data, a_dq.pop_front());
            chk("a_pc", 128'(a_out_pc), 128'(a_pq.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1 && b_out_valid && b_out_ready) begin
         if (b_dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected actual=%0h required=none", b_out_data);
         end else begin
            chk("b_data", 128'(b_out_data), 128'(b_dq.pop_front()));
            chk("b_pc", 128'(b_out_pc), 128'(b_pq.pop_front()));
         end
      end
   end

   initial begin
      // 1: reset
      repeat (3) tick();
      chk("rst_hold_valid", 128'(a_out_valid), 128'd0);
      chk("rst_hold_pc", 128'(a_out_pc), 128'h3008);
      rst = 1'b1;
      tick();
      chk("rst_valid", 128'(a_out_valid), 128'd0);
      chk("rst_data", a_out_data, 128'd0);
      chk("rst_pc", 128'(a_out_pc), 128'h3008);
      chk("rst_occ", 128'(a_occ), 128'd0);
      chk("rst_in_ready", 128'(a_in_ready), 128'd1);
      chk("b_rst_pc", 128'(b_out_pc), 128'h3008);
      chk("b_rst_in_ready", 128'(b_in_ready), 128'd1);

      // 2: streaming
      a_out_ready = 1'b1;
      for (int v = 1; v <= 4; v++) begin
         send_a(v, 32'h100 + 32'(4 * v));
         a_dq.push_back(wa(v));
         a_pq.push_back(32'h100 + 32'(4 * v));
         tick();
         chk("stream_in_ready", 128'(a_in_ready), 128'd1);
         chk("stream_valid", 128'(a_out_valid), 128'd1);
         chk("stream_data", a_out_data, wa(v));
      end
      a_in_valid = 1'b0;
      repeat (2) tick();
      chk("stream_drained", 128'(a_dq.size()), 128'd0);

      // 3: backpressure
      send_a(5, 32'h214); a_dq.push_back(wa(5)); a_pq.push_back(32'h214);
      tick();
      a_out_ready = 1'b0;
      send_a(6, 32'h218); a_dq.push_back(wa(6)); a_pq.push_back(32'h218);
      tick();
      send_a(7, 32'h21c); a_dq.push_back(wa(7)); a_pq.push_back(32'h21c);
      chk("bp_occ", 128'(a_occ), 128'd2);
      chk("bp_in_ready", 128'(a_in_ready), 128'd0);
      repeat (3) tick();
      chk("bp_hold_occ", 128'(a_occ), 128'd2);
      chk("bp_hold_data", a_out_data, wa(5));
      a_out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (a_in_ready) begin
            tick();
            break;
         end
         tick();
         if (i == 9) begin
            checks++;
            errors++;
            $display("FAIL bp_timeout actual=in_ready_low required=in_ready_high");
         end
      end
      a_in_valid = 1'b0;
      repeat (4) tick();
      chk("bp_drained", 128'(a_dq.size()), 128'd0);
      chk("bp_empty_occ", 128'(a_occ), 128'd0);

      // 4: flush while in TWO
      a_out_ready = 1'b0;
      send_a(8, 32'h320); tick();
      send_a(9, 32'h324); tick();
      chk("pre_flush_occ", 128'(a_occ), 128'd2);
      send_a(10, 32'h4010);
      a_flush = 1'b1;
      tick();
      a_flush    = 1'b0;
      a_in_valid = 1'b0;
      chk("flush_valid", 128'(a_out_valid), 128'd0);
      chk("flush_data", a_out_data, 128'd0);
      chk("flush_pc", 128'(a_out_pc), 128'h4010);
      chk("flush_occ", 128'(a_occ), 128'd0);
      chk("flush_in_ready", 128'(a_in_ready), 128'd1);
      a_out_ready = 1'b1;
      repeat (4) tick();
      chk("flush_nothing_late", 128'(a_out_valid), 128'd0);

      // 5: SKID=0 stall and replace without a bubble
      b_in_valid = 1'b1; b_in_data = 32'h0001_0002; b_in_pc = 32'h200;
      b_dq.push_back(32'h0001_0002); b_pq.push_back(32'h200);
      tick();
      b_in_valid = 1'b0;
      chk("b_stall_in_ready", 128'(b_in_ready), 128'd0);
      chk("b_stall_occ", 128'(b_occ), 128'd1);
      b_out_ready = 1'b1;
      b_in_valid = 1'b1; b_in_data = 32'h0003_0004; b_in_pc = 32'h204;
      b_dq.push_back(32'h0003_0004); b_pq.push_back(32'h204);
      #1;
      chk("b_comb_in_ready", 128'(b_in_ready), 128'd1);
      tick();
      b_in_valid = 1'b0;
      chk("b_nobubble_valid", 128'(b_out_valid), 128'd1);
      chk("b_nobubble_data", 128'(b_out_data), 128'h0003_0004);
      tick();
      chk("b_drain_valid", 128'(b_out_valid), 128'd0);
      chk("b_drained", 128'(b_dq.size()), 128'd0);

      // 6: asynchronous reset mid-cycle with occupancy 2
      a_out_ready = 1'b0;
      send_a(11, 32'h500); tick();
      send_a(12, 32'h504); tick();
      a_in_valid = 1'b0;
      chk("pre_arst_occ", 128'(a_occ), 128'd2);
      #3 rst = 1'b0;
      #2;
      chk("arst_valid", 128'(a_out_valid), 128'd0);
      chk("arst_data", a_out_data, 128'd0);
      chk("arst_pc", 128'(a_out_pc), 128'h3008);
      chk("arst_occ", 128'(a_occ), 128'd0);
      chk("arst_in_ready", 128'(a_in_ready), 128'd1);
      tick();
      rst = 1'b1;
      a_out_ready = 1'b1;
      repeat (4) tick();
      chk("arst_no_stale", 128'(a_out_valid), 128'd0);
      chk("a_queue_empty", 128'(a_dq.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage datapath; one instance per boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries NFIELD data words of DATA_W bits plus a PC sideband.
- Adds valid/ready flow control, synchronous flush to a bubble, and an optional 2-entry skid buffer so upstream stall logic is registered.

Parameters:
DATA_W, 32, width of each data field
NFIELD, 4, number of data fields carried (e.g. instr, imm, rd1, rd2)
PC_W, 32, PC sideband width
PC_RST, 32'h0000_3008, PC sideband value after reset
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
flush  input  1  synchronous clear: pipeline becomes a bubble
in_valid  input  1  upstream has a word
in_ready  output  1  stage can accept a word
in_data  input  NFIELD*DATA_W  concatenated fields, field 0 in LSBs
in_pc  input  PC_W  PC sideband
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts
out_data  output  NFIELD*DATA_W  registered fields
out_pc  output  PC_W  registered PC sideband
occupancy  output  2  number of words held (0..2; 0..1 when SKID=0)

Behaviour:
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_pc=PC_RST, occupancy=0.
  - Skid entry cleared.
  - in_ready=1 when SKID=1 (registered). When SKID=0, in_ready follows its combinational equation.
  - Release is synchronous to clk; the first capture can occur on the first rising edge after release.
- All outputs are registered except in_ready when SKID=0.

SKID=0:
- in_ready = out_ready | !out_valid.
- On in_fire: out_data<=in_data, out_pc<=in_pc, out_valid<=1.
- On out_fire without in_fire: out_valid<=0. out_data and out_pc hold their last value.
- Latency: 1 cycle.
- Full throughput: accepts every cycle while out_ready=1.

SKID=1 state machine:
- EMPTY (occ 0), ONE (occ 1, main entry valid), TWO (occ 2, main and skid valid).
- in_ready = (state != TWO), registered.
- EMPTY:
  - in_fire -> ONE; main <= input.
- ONE:
  - in_fire & out_fire -> ONE; main <= input.
  - in_fire & !out_fire -> TWO; skid <= input.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- TWO (in_ready=0):
  - out_fire -> ONE; main <= skid.
  - Otherwise hold.
- Ordering and throughput: order is strictly FIFO; there is no bypass from in_data to out_data. Latency is 1 cycle when EMPTY. Sustained throughput is 1 word/cycle.

Flush (both modes):
- Synchronous; priority over all transfers.
- Effects on the flush edge:
  - state -> EMPTY, out_valid<=0, out_data<=0, skid cleared.
  - Any in_fire in the same cycle is dropped.
  - in_ready<=1 (SKID=1).
- out_pc<=in_pc even when flushing, so the bubble carries the current PC for exception/branch bookkeeping.
- In all other cycles out_pc changes only together with out_data.
- Flush during stall (TWO, out_ready=0): both words discarded, occupancy -> 0 next cycle.

Other rules:
- in_valid deasserted without a transfer: no state change.
- in_data may change freely when in_ready=0.
- Downstream may drop out_ready at any time; out_valid and out_data are held stable until out_fire.
- Reset asserted mid-operation: immediate return to reset values, regardless of flush or handshakes.
- occupancy equals the number of held words in every cycle; it never exceeds 2 (1 when SKID=0).

Test Plan:
1. Reset: hold rst=0 for 3 cycles, then release. Required: out_valid=0, out_data=0, out_pc=32'h0000_3008, occupancy=0, in_ready=1.
2. Streaming (SKID=1, out_ready=1): in_data=1,2,3,4 on consecutive cycles. Required: out_data=1,2,3,4 one cycle later, out_valid=1 each cycle, in_ready stays 1.
3. Backpressure (SKID=1): drop out_ready after word 5 is captured, then send word 6.
   - Required: occupancy=2 and in_ready=0; word 7 is held off.
   - Raise out_ready: outputs 5, 6, 7 in order, none lost or duplicated.
4. Flush in TWO state with in_valid=1, in_pc=32'h0000_4010.
   - Required next cycle: out_valid=0, out_data=0, out_pc=32'h0000_4010, occupancy=0, in_ready=1.
   - The incoming word is not delivered later.
5. SKID=0, NFIELD=2, DATA_W=16: stall with out_ready=0 while out_valid=1. Required: in_ready=0 combinationally; in_fire with out_fire in the same cycle replaces the word with no bubble.
6. Asynchronous reset asserted mid-cycle while occupancy=2. Required: outputs return to reset values before the next clock edge; no stale word appears after release.
